irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter SOURCES, default 8, giving the number of interrupt sources (1..31); sources are numbered 1..SOURCES and ID 0 means "none".
REQ-002 SHALL have parameter PRIO_WIDTH, default 3, giving the priority and threshold width in bits.
REQ-003 SHALL have a derived localparam ID_WIDTH = $clog2(SOURCES+1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port action_sel, input, 3 bits: register select.
REQ-007 SHALL have port src_sel, input, ID_WIDTH bits: source ID for per-source registers.
REQ-008 SHALL have port wdata, input, 32 bits: write data.
REQ-009 SHALL have port wenable, input, 1 bit: write strobe.
REQ-010 SHALL have port renable, input, 1 bit: read strobe, used only to trigger the CLAIM side effect.
REQ-011 SHALL have port rdata, output, 32 bits: combinational read data, zero-extended.
REQ-012 SHALL have port int_signal, input, SOURCES bits: raw source lines, already synchronous to clk; bit i is ID i+1.
REQ-013 SHALL have port out_int_pending, output, 1 bit: an eligible interrupt exists.
REQ-014 SHALL have port out_int_id, output, ID_WIDTH bits: the winning ID, or 0 when none.

Function
REQ-015 SHALL decode action_sel as:
- 0 = PRIORITY[src], read/write.
- 1 = ENABLE[src], bit 0, read/write.
- 2 = PENDING[src], read, write-1-clears.
- 3 = MODE[src], bit 0, read/write; 0 = level, 1 = edge.
- 4 = THRESHOLD, read/write; src_sel ignored.
- 5 = CLAIM/COMPLETE.
- 6 and 7 read 0 and ignore writes.
REQ-016 SHALL make per-source accesses with src_sel = 0 or src_sel > SOURCES read 0 and ignore writes.
REQ-017 SHALL, in level mode, set pending in any cycle where the line is high and the source is not in service.
REQ-018 SHALL, in edge mode, set pending on a rising edge (line high now, low in the previous cycle), independent of in-service state.
REQ-019 SHALL treat a source as eligible when all hold: pending, enabled, not in service, and priority > THRESHOLD; priority 0 never interrupts.
REQ-020 SHALL select the eligible source with the highest priority, and the lowest ID on a tie.
REQ-021 SHALL register out_int_pending and out_int_id from the arbitration result, giving 1-cycle latency from any state change to the outputs.
REQ-022 SHALL return the registered out_int_id on a CLAIM read.
REQ-023 SHALL, when renable is high and action_sel = 5 with a nonzero ID, clear that source's pending bit and set its in-service bit at the clock edge.
REQ-024 SHALL make a CLAIM read that returns ID 0 change no state.
REQ-025 SHALL, on a write to action 5 (COMPLETE), clear the in-service bit of ID wdata[ID_WIDTH-1:0].
REQ-026 SHALL ignore a COMPLETE whose ID is 0, is above SOURCES, or is not in service.
REQ-027 SHALL, when an edge-mode set and a claim or W1C clear of the same source fall in the same cycle, leave pending set (set wins).
REQ-028 SHALL re-pend a level source on the cycle after COMPLETE if its line is still high.
REQ-029 SHALL, when wenable and renable are both high on action 5, perform the claim first and then the complete.
REQ-030 SHALL make changes to THRESHOLD, ENABLE or PRIORITY take effect on the outputs 1 cycle after the write.

Reset
REQ-031 SHALL, on a clock edge with rst = 1, clear PRIORITY, ENABLE, PENDING, MODE, in-service, THRESHOLD and the previous-sample register.
REQ-032 SHALL drive out_int_pending = 0 and out_int_id = 0 in the cycle after a reset edge.
REQ-033 SHALL make rst win over every simultaneous access.
REQ-034 SHALL make a claim that is outstanding when reset arrives be forgotten; a later COMPLETE for it is ignored.

Configuration
REQ-035 SHALL, when macro IRQ_EDGE_MODE_EN is defined, implement MODE registers and edge detection as specified above.
REQ-036 SHALL, when IRQ_EDGE_MODE_EN is undefined, treat all sources as level: MODE reads 0, MODE writes are ignored, and no previous-sample register is built.

Structure
REQ-037 SHALL take the action_sel codes (ACT_PRIORITY ... ACT_CLAIM) and the MODE encodings from shared package irq_pkg.
REQ-038 SHALL instantiate one irq_gateway sub-module per source, holding that source's pending, in-service, mode and edge-detect state; the top holds the registers, the arbiter and the output flops.

Verification
REQ-039 SHALL cover a level claim: source 3 with priority 2, enabled, THRESHOLD 0; raise int_signal[2] -> outputs 1/3 after 1 cycle; CLAIM read returns 3 -> outputs 0/0 next cycle; COMPLETE 3 with line still high -> outputs 1/3 again.
REQ-040 SHALL cover arbitration ties: sources 2 and 5 at priority 4 and source 7 at priority 3, all pending -> ID 2; after claiming 2 -> ID 5; after claiming 5 -> ID 7.
REQ-041 SHALL cover the threshold: source 1 at priority 2 pending; THRESHOLD = 2 -> outputs 0/0; THRESHOLD = 1 -> outputs 1/1 after 1 cycle.
REQ-042 SHALL cover edge mode (IRQ_EDGE_MODE_EN defined): source 4 in edge mode, pulse int_signal[3] for 1 cycle while source 4 is in service -> PENDING[4] reads 1; after COMPLETE 4 -> outputs 1/4.
REQ-043 SHALL cover an empty claim: no sources pending -> CLAIM read returns 0 and no state changes.
REQ-044 SHALL cover reset during service: COMPLETE 9 with SOURCES = 8 -> ignored; rst pulsed while source 2 is in service -> all registers read 0 and outputs are 0/0.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared register-select codes and source trigger modes
package irq_pkg;

    typedef enum logic [2:0] {
        ACT_PRIORITY  = 3'd0,
        ACT_ENABLE    = 3'd1,
        ACT_PENDING   = 3'd2,
        ACT_MODE      = 3'd3,
        ACT_THRESHOLD = 3'd4,
        ACT_CLAIM     = 3'd5
    } irq_action_e;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } irq_mode_e;

endpackage

// File: rtl/irq_gateway.sv
// rtl/irq_gateway.sv - per-source pending/in-service state; edge detect only with IRQ_EDGE_MODE_EN
module irq_gateway
    import irq_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      line,
`ifdef IRQ_EDGE_MODE_EN
    input  irq_mode_e mode,
`endif
    input  logic      claim,
    input  logic      clear,
    input  logic      complete,
    output logic      pending,
    output logic      in_service
);

    logic edge_set;
    logic level_set;

`ifdef IRQ_EDGE_MODE_EN
    logic prev_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_line <= 1'b0;
        end else begin
            prev_line <= line;
        end
    end

    assign edge_set  = (mode == MODE_EDGE) && line && !prev_line;
    assign level_set = (mode == MODE_LEVEL) && line && !in_service;
`else
    assign edge_set  = 1'b0;
    assign level_set = line && !in_service;
`endif

    // A fresh edge survives a same-cycle clear; a level request yields to it
    // and re-arms once the source leaves service.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            if (edge_set) begin
                pending <= 1'b1;
            end else if (claim || clear) begin
                pending <= 1'b0;
            end else if (level_set) begin
                pending <= 1'b1;
            end
            in_service <= (in_service | claim) & ~complete;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised interrupt controller top; MODE registers only with IRQ_EDGE_MODE_EN
module irq_controller
    import irq_pkg::*;
#(
    parameter  int SOURCES    = 8,
    parameter  int PRIO_WIDTH = 3,
    localparam int ID_WIDTH   = $clog2(SOURCES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          action_sel,
    input  logic [ID_WIDTH-1:0] src_sel,
    input  logic [31:0]         wdata,
    input  logic                wenable,
    input  logic                renable,
    output logic [31:0]         rdata,
    input  logic [SOURCES-1:0]  int_signal,
    output logic                out_int_pending,
    output logic [ID_WIDTH-1:0] out_int_id
);

    irq_action_e           act;
    logic [PRIO_WIDTH-1:0] priority_q [SOURCES];
    logic [PRIO_WIDTH-1:0] threshold_q;
    logic [PRIO_WIDTH-1:0] best_prio;
    logic [ID_WIDTH-1:0]   best_id;
    logic [ID_WIDTH-1:0]   complete_id;
    logic [SOURCES-1:0]    enable_q;
    logic [SOURCES-1:0]    pending;
    logic [SOURCES-1:0]    in_service;
    logic [SOURCES-1:0]    src_hit;
    logic [SOURCES-1:0]    claim_hit;
    logic [SOURCES-1:0]    clear_hit;
    logic [SOURCES-1:0]    complete_hit;
    logic                  unused_wdata;
`ifdef IRQ_EDGE_MODE_EN
    logic [SOURCES-1:0]    mode_q;
`endif

    assign act          = irq_action_e'(action_sel);
    assign complete_id  = wdata[ID_WIDTH-1:0];
    assign unused_wdata = &{1'b0, wdata};

    // ID 0 and IDs above SOURCES match no source, so they fall out as no-ops.
    always_comb begin
        src_hit      = '0;
        claim_hit    = '0;
        clear_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < SOURCES; i++) begin
            src_hit[i]      = (src_sel == ID_WIDTH'(i + 1));
            claim_hit[i]    = renable && (act == ACT_CLAIM) && (out_int_id == ID_WIDTH'(i + 1));
            clear_hit[i]    = wenable && (act == ACT_PENDING) && src_hit[i] && wdata[0];
            complete_hit[i] = wenable && (act == ACT_CLAIM) && (complete_id == ID_WIDTH'(i + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            threshold_q <= '0;
            enable_q    <= '0;
            for (int i = 0; i < SOURCES; i++) begin
                priority_q[i] <= '0;
            end
`ifdef IRQ_EDGE_MODE_EN
            mode_q      <= '0;
`endif
        end else if (wenable) begin
            if (act == ACT_THRESHOLD) begin
                threshold_q <= wdata[PRIO_WIDTH-1:0];
            end
            for (int i = 0; i < SOURCES; i++) begin
                if (src_hit[i]) begin
                    if (act == ACT_PRIORITY) priority_q[i] <= wdata[PRIO_WIDTH-1:0];
                    if (act == ACT_ENABLE)   enable_q[i]   <= wdata[0];
`ifdef IRQ_EDGE_MODE_EN
                    if (act == ACT_MODE)     mode_q[i]     <= wdata[0];
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < SOURCES; g++) begin : g_src
        irq_gateway u_gateway (
            .clk        (clk),
            .rst        (rst),
            .line       (int_signal[g]),
`ifdef IRQ_EDGE_MODE_EN
            .mode       (irq_mode_e'(mode_q[g])),
`endif
            .claim      (claim_hit[g]),
            .clear      (clear_hit[g]),
            .complete   (complete_hit[g]),
            .pending    (pending[g]),
            .in_service (in_service[g])
        );
    end

    // Seeding with the threshold makes "priority > threshold" implicit; strict
    // compare keeps the lowest ID on a tie.
    always_comb begin
        best_prio = threshold_q;
        best_id   = '0;
        for (int i = 0; i < SOURCES; i++) begin
            if (pending[i] && enable_q[i] && !in_service[i] && (priority_q[i] > best_prio)) begin
                best_prio = priority_q[i];
                best_id   = ID_WIDTH'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_int_pending <= 1'b0;
            out_int_id      <= '0;
        end else begin
            out_int_pending <= (best_id != '0);
            out_int_id      <= best_id;
        end
    end

    always_comb begin
        rdata = '0;
        case (act)
            ACT_THRESHOLD: rdata = 32'(threshold_q);
            ACT_CLAIM:     rdata = 32'(out_int_id);
            ACT_PRIORITY, ACT_ENABLE, ACT_PENDING, ACT_MODE: begin
                for (int i = 0; i < SOURCES; i++) begin
                    if (src_hit[i]) begin
                        if (act == ACT_PRIORITY)     rdata = 32'(priority_q[i]);
                        else if (act == ACT_ENABLE)  rdata = 32'(enable_q[i]);
                        else if (act == ACT_PENDING) rdata = 32'(pending[i]);
`ifdef IRQ_EDGE_MODE_EN
                        else if (act == ACT_MODE)    rdata = 32'(mode_q[i]);
`endif
                    end
                end
            end
            default:       rdata = '0;
        endcase
    end

endmodule
